decoding_block: RTL and testbench
=================================

DECODING_BLOCK -- requirements
Module: decoding_block

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the saturating sync-error counter.
REQ-002 dec_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 enable  input  1  block enable; low = synchronous flush to idle.
REQ-005 gen_speed  input  2  0 = Gen4 byte pass-through; 1 = Gen3 128b/132b; 2 = Gen2 64b/66b; 3 = reserved.
REQ-006 enc_valid  input  1  one-cycle strobe: new encoded symbol present on both lane inputs.
REQ-007 lane_0_rx_enc  input  132  lane 0 encoded symbol; sync header in LSBs, data byte k above it.
REQ-008 lane_1_rx_enc  input  132  lane 1 encoded symbol, same layout.
REQ-009 lane_0_rx  output  8  lane 0 decoded byte.
REQ-010 lane_1_rx  output  8  lane 1 decoded byte.
REQ-011 rx_valid  output  1  lane_0_rx/lane_1_rx hold a valid byte this cycle.
REQ-012 os_flag  output  1  current byte belongs to an ordered set (1) or transport data (0).
REQ-013 sym_start  output  1  high with the first byte of each decoded symbol.
REQ-014 sync_err  output  1  one-cycle pulse: symbol rejected for bad header.
REQ-015 overflow  output  1  one-cycle pulse: symbol dropped because unload still in progress.
REQ-016 err_cnt  output  ERR_CNT_W  saturating count of sync_err events.

Function
REQ-017 Two states: IDLE, UNLOAD; byte index counter idx (4 bits) and latched speed spd_q.
REQ-018 Header, Gen3: bits[3:0] 4'b0101 = ordered set, 4'b1010 = transport; any other value = invalid.
REQ-019 Header, Gen2: bits[1:0] 2'b01 = ordered set, 2'b10 = transport; 2'b00/2'b11 = invalid; bits[131:66] ignored.
REQ-020 Symbol invalid if either lane header invalid or lane 0 and lane 1 headers differ.
REQ-021 Accept condition: enc_valid, enable high, gen_speed 1 or 2, and (state IDLE or idx at last byte).
REQ-022 On accept with valid header: both symbols and type captured, spd_q <= gen_speed, idx <= 0, state <= UNLOAD.
REQ-023 On accept with invalid header: symbol discarded, sync_err pulses next cycle, err_cnt += 1 saturating at all-ones, state unchanged except UNLOAD completing normally.
REQ-024 UNLOAD: one byte per lane per cycle, first byte registered the cycle after capture (latency 1); byte k = bits[4+8k+7 : 4+8k] (Gen3, k=0..15) or bits[2+8k+7 : 2+8k] (Gen2, k=0..7).
REQ-025 rx_valid high for every UNLOAD byte; sym_start high only on k=0; os_flag constant for the symbol.
REQ-026 After last byte (k=15 Gen3, k=7 Gen2): IDLE, unless a new accept occurred that cycle -> next symbol's k=0 follows with no gap.
REQ-027 enc_valid in UNLOAD before last byte: symbol dropped, overflow pulses next cycle, current unload unaffected.
REQ-028 gen_speed change during UNLOAD ignored until next accept; spd_q governs unload length.
REQ-029 gen_speed 0: lane_x_rx <= lane_x_rx_enc[7:0] and rx_valid <= enc_valid each cycle; os_flag 0, sym_start = rx_valid, no header check.
REQ-030 gen_speed 3: no capture; enc_valid ignored; no error or overflow reported.
REQ-031 enable low: state IDLE, idx 0, rx_valid/sym_start/os_flag/sync_err/overflow 0, byte outputs 0; err_cnt held.
REQ-032 Outputs when rx_valid low: lane_x_rx = 0, os_flag = 0, sym_start = 0.

Reset
REQ-033 rst low asynchronously forces IDLE, idx 0, spd_q 0, all outputs 0 including err_cnt, captured symbols 0.
REQ-034 rst asserted mid-UNLOAD aborts the symbol; no remaining bytes emitted after release.

Verification
REQ-035 Gen3, lane 0 = {bytes 0x0F..0x00 as k=15..0, 4'b1010}, enc_valid 1 cycle -> 16 cycles rx_valid, lane_0_rx 0x00,0x01..0x0F, os_flag 0, sym_start on first.
REQ-036 Gen2, header 2'b01 both lanes, bytes 0xA0..0xA7 -> 8 bytes in order, os_flag 1; second enc_valid on 8th byte cycle -> next symbol k=0 with no gap.
REQ-037 Gen3, lane 0 header 4'b0101, lane 1 4'b1010 -> no rx_valid, sync_err 1 cycle, err_cnt 0->1; 256 bad symbols with ERR_CNT_W=8 -> err_cnt stays 0xFF.
REQ-038 Gen2, enc_valid again at k=3 -> overflow pulse, original 8 bytes complete intact, dropped symbol never output.
REQ-039 Gen4, lane_0_rx_enc[7:0] = 0x5A with enc_valid -> next cycle lane_0_rx 0x5A, rx_valid 1; rst low at Gen3 k=5 -> all outputs 0 immediately, no further bytes.

Source files
------------

// File: rtl/decoding_block.sv
// Two-lane symbol decoder: strips 128b/132b or 64b/66b sync headers and
// streams the payload out one byte per lane per cycle, or passes raw bytes
// through in Gen4 mode. Counts header errors with a saturating counter.
module decoding_block #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 dec_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           gen_speed,
    input  logic                 enc_valid,
    input  logic [131:0]         lane_0_rx_enc,
    input  logic [131:0]         lane_1_rx_enc,
    output logic [7:0]           lane_0_rx,
    output logic [7:0]           lane_1_rx,
    output logic                 rx_valid,
    output logic                 os_flag,
    output logic                 sym_start,
    output logic                 sync_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StUnload
    } state_e;

    localparam logic [1:0] SpdGen4 = 2'd0;
    localparam logic [1:0] SpdGen3 = 2'd1;
    localparam logic [1:0] SpdGen2 = 2'd2;

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [1:0]             spd_q, spd_d;
    logic                   os_q, os_d;
    // Payload with the header already stripped; Gen2 uses the low 64 bits.
    logic [127:0]           sym0_q, sym0_d;
    logic [127:0]           sym1_q, sym1_d;
    logic                   pt_valid_q, pt_valid_d;
    logic [7:0]             pt0_q, pt0_d;
    logic [7:0]             pt1_q, pt1_d;
    logic                   sync_err_q, sync_err_d;
    logic                   overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   hdr_valid;
    logic                   hdr_os;
    logic                   spd_ok;
    logic                   last_byte;
    logic                   busy;
    logic                   accept;

    // Header classification for the incoming symbol pair at the requested speed.
    always_comb begin
        hdr_valid = 1'b0;
        hdr_os    = 1'b0;
        case (gen_speed)
            SpdGen3: begin
                hdr_valid = (lane_0_rx_enc[3:0] == lane_1_rx_enc[3:0]) &&
                            ((lane_0_rx_enc[3:0] == 4'b0101) ||
                             (lane_0_rx_enc[3:0] == 4'b1010));
                hdr_os    = (lane_0_rx_enc[3:0] == 4'b0101);
            end
            SpdGen2: begin
                hdr_valid = (lane_0_rx_enc[1:0] == lane_1_rx_enc[1:0]) &&
                            ((lane_0_rx_enc[1:0] == 2'b01) ||
                             (lane_0_rx_enc[1:0] == 2'b10));
                hdr_os    = (lane_0_rx_enc[1:0] == 2'b01);
            end
            default: begin
                hdr_valid = 1'b0;
                hdr_os    = 1'b0;
            end
        endcase
    end

    // Accept control: a new symbol may land only when idle or on the final byte.
    always_comb begin
        spd_ok    = (gen_speed == SpdGen3) || (gen_speed == SpdGen2);
        last_byte = (spd_q == SpdGen3) ? (idx_q == 4'd15) : (idx_q == 4'd7);
        busy      = (state_q == StUnload) && !last_byte;
        accept    = enable && enc_valid && spd_ok && !busy;
    end

    // Next-state: unload sequencing, capture, error and overflow reporting.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        spd_d      = spd_q;
        os_d       = os_q;
        sym0_d     = sym0_q;
        sym1_d     = sym1_q;
        sync_err_d = 1'b0;
        overflow_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (!enable) begin
            state_d = StIdle;
            idx_d   = 4'd0;
        end else begin
            if (state_q == StUnload) begin
                if (last_byte) begin
                    state_d = StIdle;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            if (accept) begin
                if (hdr_valid) begin
                    state_d = StUnload;
                    idx_d   = 4'd0;
                    spd_d   = gen_speed;
                    os_d    = hdr_os;
                    if (gen_speed == SpdGen3) begin
                        sym0_d = lane_0_rx_enc[131:4];
                        sym1_d = lane_1_rx_enc[131:4];
                    end else begin
                        sym0_d = {64'd0, lane_0_rx_enc[65:2]};
                        sym1_d = {64'd0, lane_1_rx_enc[65:2]};
                    end
                end else begin
                    sync_err_d = 1'b1;
                    if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end

            // A symbol arriving mid-unload is dropped; the current one keeps going.
            if (enc_valid && spd_ok && busy) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Gen4 pass-through stage; bytes are zeroed whenever they are not valid.
    always_comb begin
        pt_valid_d = enable && (gen_speed == SpdGen4) && enc_valid;
        pt0_d      = pt_valid_d ? lane_0_rx_enc[7:0] : 8'd0;
        pt1_d      = pt_valid_d ? lane_1_rx_enc[7:0] : 8'd0;
    end

    // State and output-side registers.
    always_ff @(posedge dec_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            spd_q      <= 2'd0;
            os_q       <= 1'b0;
            sym0_q     <= '0;
            sym1_q     <= '0;
            pt_valid_q <= 1'b0;
            pt0_q      <= 8'd0;
            pt1_q      <= 8'd0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spd_q      <= spd_d;
            os_q       <= os_d;
            sym0_q     <= sym0_d;
            sym1_q     <= sym1_d;
            pt_valid_q <= pt_valid_d;
            pt0_q      <= pt0_d;
            pt1_q      <= pt1_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Output mux: unload bytes take priority over pass-through.
    always_comb begin
        lane_0_rx = 8'd0;
        lane_1_rx = 8'd0;
        rx_valid  = 1'b0;
        os_flag   = 1'b0;
        sym_start = 1'b0;
        if (state_q == StUnload) begin
            lane_0_rx = sym0_q[{idx_q, 3'b000} +: 8];
            lane_1_rx = sym1_q[{idx_q, 3'b000} +: 8];
            rx_valid  = 1'b1;
            os_flag   = os_q;
            sym_start = (idx_q == 4'd0);
        end else if (pt_valid_q) begin
            lane_0_rx = pt0_q;
            lane_1_rx = pt1_q;
            rx_valid  = 1'b1;
            sym_start = 1'b1;
        end
        sync_err = sync_err_q;
        overflow = overflow_q;
        err_cnt  = err_cnt_q;
    end

endmodule

// File: tb/tb_decoding_block.sv
// Self-checking bench for decoding_block: a byte-queue reference model is
// compared against the DUT every cycle, with directed literal checks on top.
module tb_decoding_block;

    localparam int W = 8;

    logic           dec_clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [1:0]     gen_speed;
    logic           enc_valid;
    logic [131:0]   lane_0_rx_enc;
    logic [131:0]   lane_1_rx_enc;
    logic [7:0]     lane_0_rx;
    logic [7:0]     lane_1_rx;
    logic           rx_valid;
    logic           os_flag;
    logic           sym_start;
    logic           sync_err;
    logic           overflow;
    logic [W-1:0]   err_cnt;

    always #5 dec_clk = ~dec_clk;

    decoding_block #(.ERR_CNT_W(W)) dut (
        .dec_clk      (dec_clk),
        .rst          (rst),
        .enable       (enable),
        .gen_speed    (gen_speed),
        .enc_valid    (enc_valid),
        .lane_0_rx_enc(lane_0_rx_enc),
        .lane_1_rx_enc(lane_1_rx_enc),
        .lane_0_rx    (lane_0_rx),
        .lane_1_rx    (lane_1_rx),
        .rx_valid     (rx_valid),
        .os_flag      (os_flag),
        .sym_start    (sym_start),
        .sync_err     (sync_err),
        .overflow     (overflow),
        .err_cnt      (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic       os;
        logic       st;
        logic [7:0] b0;
        logic [7:0] b1;
    } out_t;

    // Model: bytes still to be shown, the byte shown now, pulses, error tally.
    out_t   mq[$];
    out_t   cur;
    logic   m_serr;
    logic   m_ovf;
    int     m_errs;
    bit     cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hdr_kind(input logic [1:0] g, input logic [131:0] e);
        if (g == 2'd1) begin
            if (e[3:0] == 4'b0101) return 1;
            if (e[3:0] == 4'b1010) return 0;
            return -1;
        end
        if (e[1:0] == 2'b01) return 1;
        if (e[1:0] == 2'b10) return 0;
        return -1;
    endfunction

    function automatic logic [7:0] byte_at(input logic [131:0] e, input int sh);
        logic [131:0] t;
        t = e >> sh;
        return t[7:0];
    endfunction

    function automatic logic [131:0] mk3(input logic [7:0] base, input logic [3:0] hdr);
        logic [131:0] e;
        e      = '0;
        e[3:0] = hdr;
        for (int k = 0; k < 16; k++) e[4+8*k +: 8] = base + 8'(k);
        return e;
    endfunction

    // Bits above the 66-bit Gen2 block are set to ones; they must be ignored.
    function automatic logic [131:0] mk2(input logic [7:0] base, input logic [1:0] hdr);
        logic [131:0] e;
        e      = '1;
        e[1:0] = hdr;
        for (int k = 0; k < 8; k++) e[2+8*k +: 8] = base + 8'(k);
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        cur    = '0;
        m_serr = 1'b0;
        m_ovf  = 1'b0;
        m_errs = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        out_t nxt;
        bit   sym_spd;
        int   k0, k1, n, off;
        if (!rst) begin
            model_reset();
            return;
        end
        m_serr = 1'b0;
        m_ovf  = 1'b0;
        if (!enable) begin
            mq.delete();
            cur = '0;
            return;
        end
        nxt     = '0;
        sym_spd = (gen_speed == 2'd1) || (gen_speed == 2'd2);
        if (mq.size() != 0) begin
            if (enc_valid && sym_spd) m_ovf = 1'b1;
            nxt = mq.pop_front();
        end else if (enc_valid && sym_spd) begin
            k0 = hdr_kind(gen_speed, lane_0_rx_enc);
            k1 = hdr_kind(gen_speed, lane_1_rx_enc);
            if (k0 >= 0 && k0 == k1) begin
                n   = (gen_speed == 2'd1) ? 16 : 8;
                off = (gen_speed == 2'd1) ? 4 : 2;
                for (int k = 0; k < n; k++) begin
                    mq.push_back('{v: 1'b1, os: (k0 == 1), st: (k == 0),
                                   b0: byte_at(lane_0_rx_enc, off + 8*k),
                                   b1: byte_at(lane_1_rx_enc, off + 8*k)});
                end
                nxt = mq.pop_front();
            end else begin
                m_serr = 1'b1;
                m_errs++;
            end
        end else if (enc_valid && gen_speed == 2'd0) begin
            nxt = '{v: 1'b1, os: 1'b0, st: 1'b1,
                    b0: lane_0_rx_enc[7:0], b1: lane_1_rx_enc[7:0]};
        end
        cur = nxt;
    endtask

    task automatic step();
        @(posedge dec_clk);
        model_edge();
        #1;
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge dec_clk) begin
        if (cmp_en) begin
            chk("cycle", {3'b0, rx_valid, os_flag, sym_start, sync_err, overflow,
                          lane_0_rx, lane_1_rx, err_cnt},
                {3'b0, cur.v, cur.os, cur.st, m_serr, m_ovf, cur.b0, cur.b1,
                 8'((m_errs > 255) ? 255 : m_errs)});
        end
    end

    logic [7:0] prev_cnt;

    initial begin
        rst           = 1'b0;
        enable        = 1'b0;
        gen_speed     = 2'd0;
        enc_valid     = 1'b0;
        lane_0_rx_enc = '0;
        lane_1_rx_enc = '0;
        model_reset();
        #1;
        chk("reset_outputs", {7'b0, rx_valid, os_flag, sym_start, sync_err, overflow,
                              lane_0_rx, lane_1_rx}, 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        step();
        step();
        rst    = 1'b1;
        enable = 1'b1;
        cmp_en = 1'b1;
        step();

        // Gen3 transport symbol, bytes 0x00..0x0F on lane 0.
        gen_speed     = 2'd1;
        lane_0_rx_enc = mk3(8'h00, 4'b1010);
        lane_1_rx_enc = mk3(8'h40, 4'b1010);
        enc_valid     = 1'b1;
        step();
        enc_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("gen3_byte", {15'b0, rx_valid, os_flag, lane_0_rx, lane_1_rx},
                {15'b0, 1'b1, 1'b0, 8'(k), 8'(8'h40 + k)});
            chk("gen3_start", 32'(sym_start), 32'(k == 0));
            step();
        end
        chk("gen3_done", 32'(rx_valid), 32'd0);

        // Gen2 ordered set followed back-to-back by a second symbol.
        gen_speed     = 2'd2;
        lane_0_rx_enc = mk2(8'hA0, 2'b01);
        lane_1_rx_enc = mk2(8'h10, 2'b01);
        enc_valid     = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("gen2_byte", {14'b0, rx_valid, os_flag, lane_0_rx, lane_1_rx},
                {14'b0, 1'b1, 1'b1, 8'(8'hA0 + k), 8'(8'h10 + k)});
            if (k == 7) begin
                lane_0_rx_enc = mk2(8'hC0, 2'b10);
                lane_1_rx_enc = mk2(8'hD0, 2'b10);
                enc_valid     = 1'b1;
            end else begin
                enc_valid = 1'b0;
            end
            step();
        end
        enc_valid = 1'b0;
        chk("gen2_nogap", {13'b0, rx_valid, sym_start, os_flag, overflow, lane_0_rx, lane_1_rx},
            {13'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC0, 8'hD0});
        for (int k = 0; k < 8; k++) step();
        chk("gen2_drained", 32'(rx_valid), 32'd0);

        // Gen3 lane header mismatch.
        gen_speed     = 2'd1;
        lane_0_rx_enc = mk3(8'h20, 4'b0101);
        lane_1_rx_enc = mk3(8'h20, 4'b1010);
        enc_valid     = 1'b1;
        step();
        enc_valid = 1'b0;
        chk("mismatch_pulse", {22'b0, sync_err, rx_valid, err_cnt}, {22'b0, 1'b1, 1'b0, 8'd1});
        step();
        chk("mismatch_end", {23'b0, sync_err, err_cnt}, {23'b0, 1'b0, 8'd1});

        // Gen2 overflow at k=3; original symbol must finish intact.
        gen_speed     = 2'd2;
        lane_0_rx_enc = mk2(8'h50, 2'b10);
        lane_1_rx_enc = mk2(8'h60, 2'b10);
        enc_valid     = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("ovf_byte", {15'b0, rx_valid, os_flag, lane_0_rx, lane_1_rx},
                {15'b0, 1'b1, 1'b0, 8'(8'h50 + k), 8'(8'h60 + k)});
            if (k == 4) chk("ovf_pulse", 32'(overflow), 32'd1);
            if (k == 3) begin
                lane_0_rx_enc = mk2(8'hE0, 2'b10);
                lane_1_rx_enc = mk2(8'hF0, 2'b10);
                enc_valid     = 1'b1;
            end else begin
                enc_valid = 1'b0;
            end
            step();
        end
        chk("ovf_dropped", 32'(rx_valid), 32'd0);

        // Gen4 pass-through.
        gen_speed           = 2'd0;
        lane_0_rx_enc       = '0;
        lane_0_rx_enc[7:0]  = 8'h5A;
        lane_1_rx_enc       = '0;
        lane_1_rx_enc[7:0]  = 8'hA5;
        enc_valid           = 1'b1;
        step();
        enc_valid = 1'b0;
        chk("gen4_pass", {14'b0, rx_valid, sym_start, lane_0_rx, lane_1_rx},
            {14'b0, 1'b1, 1'b1, 8'h5A, 8'hA5});
        step();
        chk("gen4_idle", 32'(rx_valid), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 49) != 0);
            if (mq.size() == 0 && $urandom_range(0, 3) == 0) begin
                gen_speed = 2'($urandom_range(0, 3));
            end else if (mq.size() != 0 && $urandom_range(0, 9) == 0) begin
                gen_speed = 2'($urandom_range(1, 3));
            end
            enc_valid     = ($urandom_range(0, 3) == 0);
            lane_0_rx_enc = 132'({$urandom, $urandom, $urandom, $urandom, $urandom});
            lane_1_rx_enc = 132'({$urandom, $urandom, $urandom, $urandom, $urandom});
            begin
                int  kind;
                bit  os;
                kind = $urandom_range(0, 7);
                os   = 1'($urandom_range(0, 1));
                if (kind >= 2) begin
                    if (gen_speed == 2'd2) begin
                        lane_0_rx_enc[1:0] = os ? 2'b01 : 2'b10;
                        lane_1_rx_enc[1:0] = os ? 2'b01 : 2'b10;
                    end else begin
                        lane_0_rx_enc[3:0] = os ? 4'b0101 : 4'b1010;
                        lane_1_rx_enc[3:0] = os ? 4'b0101 : 4'b1010;
                    end
                end else if (kind == 1) begin
                    lane_0_rx_enc[3:0] = os ? 4'b0101 : 4'b1010;
                    lane_1_rx_enc[3:0] = os ? 4'b1010 : 4'b0101;
                end
            end
            step();
        end
        enable    = 1'b1;
        enc_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();

        // Saturation: a long run of bad symbols.
        gen_speed     = 2'd1;
        lane_0_rx_enc = mk3(8'h00, 4'b0101);
        lane_1_rx_enc = mk3(8'h00, 4'b1010);
        enc_valid     = 1'b1;
        for (int k = 0; k < 300; k++) step();
        enc_valid = 1'b0;
        step();
        chk("err_saturated", 32'(err_cnt), 32'hFF);
        prev_cnt = err_cnt;
        lane_0_rx_enc = mk3(8'h00, 4'b1111);
        enc_valid     = 1'b1;
        step();
        enc_valid = 1'b0;
        chk("err_held", {23'b0, sync_err, err_cnt}, {23'b0, 1'b1, 8'hFF});

        // Asynchronous reset in the middle of a Gen3 unload.
        lane_0_rx_enc = mk3(8'h00, 4'b1010);
        lane_1_rx_enc = mk3(8'h80, 4'b1010);
        enc_valid     = 1'b1;
        step();
        enc_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("pre_reset_k5", {23'b0, rx_valid, lane_0_rx}, {23'b0, 1'b1, 8'h05});
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset", {2'b0, rx_valid, os_flag, sym_start, sync_err, overflow,
                            lane_0_rx, lane_1_rx, err_cnt}, 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("post_reset_quiet", 32'(rx_valid), 32'd0);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
